// File: rtl/instr_prefetch_queue_if.sv
// Fetch front-end bundle: redirect/halt control, instruction RAM port and the
// decoder-side valid/ready handshake, grouped for instr_prefetch_queue.
// Ports (slave = queue view): in redirect, redirect_pc, halt, fetch_data, instr_ready;
//   out fetch_req, fetch_addr, instr_valid, instr_out, instr_pc, count.
interface instr_prefetch_queue_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  count;

  // Environment side: branch unit / RAM / decoder.
  modport master (
    output redirect, redirect_pc, halt, fetch_data, instr_ready,
    input  fetch_req, fetch_addr, instr_valid, instr_out, instr_pc, count
  );

  // Prefetch queue side.
  modport slave (
    input  redirect, redirect_pc, halt, fetch_data, instr_ready,
    output fetch_req, fetch_addr, instr_valid, instr_out, instr_pc, count
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with a DEPTH-entry {data, pc} queue in front of the decoder.
// Latency: redirect at t -> fetch at t+1 -> RAM data t+2 -> head valid t+3; 1 instr/cycle steady.
// Backpressure: fetches are credit-limited by occupancy + in-flight read; instr_ready stalls the head.
// Ports: clk, rst_n (async active-low), bus (instr_prefetch_queue_if.slave).
module instr_prefetch_queue #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_prefetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [ADDR_W-1:0] pc_q  [DEPTH];

  logic              pop;
  logic              push;
  logic              fetch_req;
  logic [CNT_W:0]    occ;

  assign pop  = (count_q != '0) && bus.instr_ready;
  // Returning data is dropped when a redirect lands in the same cycle.
  assign push = inflight_q && !bus.redirect;

  // Credit includes this cycle's pop so a full-rate stream never bubbles.
  assign occ       = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign fetch_req = (state_q == RUN) && !bus.halt && !bus.redirect &&
                     (occ < (CNT_W+1)'(DEPTH));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = fetch_req;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (bus.redirect) begin
      state_d    = RUN;
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (fetch_req) begin
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (push) begin
      dat_q[wr_ptr_q] <= bus.fetch_data;
      pc_q[wr_ptr_q]  <= inflight_pc_q;
    end
  end

  assign bus.fetch_req   = fetch_req;
  assign bus.fetch_addr  = fetch_pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_out   = dat_q[rd_ptr_q];
  assign bus.instr_pc    = pc_q[rd_ptr_q];
  assign bus.count       = count_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: RAM model returns 0xE000_0000+addr one cycle after fetch_req.
// Latency: not applicable (bench).
// Backpressure: instr_ready driven directly by the step sequence.
module tb_instr_prefetch_queue;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   nf;
  logic [10:0] e_pc;

  instr_prefetch_queue_if #(.ADDR_W(11), .DATA_W(32), .DEPTH(4)) bus ();

  instr_prefetch_queue #(.ADDR_W(11), .DATA_W(32), .DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction RAM: data for a request appears the following cycle and holds.
  initial bus.fetch_data = 32'h0;
  always @(posedge clk) begin
    if (bus.fetch_req) bus.fetch_data <= 32'hE000_0000 + {21'b0, bus.fetch_addr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   64'(bus.fetch_req),   64'(0));
    check({tag, "_addr"},  64'(bus.fetch_addr),  64'(0));
    check({tag, "_valid"}, 64'(bus.instr_valid), 64'(0));
    check({tag, "_out"},   64'(bus.instr_out),   64'(0));
    check({tag, "_pc"},    64'(bus.instr_pc),    64'(0));
    check({tag, "_count"}, 64'(bus.count),       64'(0));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 11'h0;
    bus.halt = 1'b0;
    bus.instr_ready = 1'b0;
    #2;
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_fetch", 64'(bus.fetch_req), 64'(0));

    // Stream from 0x010
    bus.redirect = 1'b1; bus.redirect_pc = 11'h010; bus.instr_ready = 1'b1;
    #1;
    check("redir_req_low", 64'(bus.fetch_req), 64'(0));
    tick(); bus.redirect = 1'b0; #1;
    check("t1_req", 64'(bus.fetch_req), 64'(1));
    check("t1_addr", 64'(bus.fetch_addr), 64'h010);
    check("t1_valid", 64'(bus.instr_valid), 64'(0));
    tick();
    check("t2_no_bypass", 64'(bus.instr_valid), 64'(0));
    tick();
    check("t3_valid", 64'(bus.instr_valid), 64'(1));
    check("t3_pc", 64'(bus.instr_pc), 64'h010);
    check("t3_out", 64'(bus.instr_out), 64'hE000_0010);
    e_pc = 11'h010;
    for (int k = 0; k < 5; k++) begin
      tick();
      e_pc = e_pc + 11'h1;
      check("stream_valid", 64'(bus.instr_valid), 64'(1));
      check("stream_pc", 64'(bus.instr_pc), 64'(e_pc));
      check("stream_out", 64'(bus.instr_out), 64'hE000_0000 + 64'(e_pc));
    end

    // Fill with consumer stalled
    bus.redirect = 1'b1; bus.redirect_pc = 11'h000; bus.instr_ready = 1'b0;
    #1;
    tick(); bus.redirect = 1'b0; #1;
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.fetch_req) begin
        check("fill_addr", 64'(bus.fetch_addr), 64'(nf));
        nf++;
      end
      tick();
    end
    check("fill_nfetch", 64'(nf), 64'(4));
    check("full_req", 64'(bus.fetch_req), 64'(0));
    check("full_count", 64'(bus.count), 64'(4));
    check("full_head_pc", 64'(bus.instr_pc), 64'h000);
    check("full_head_out", 64'(bus.instr_out), 64'hE000_0000);
    bus.instr_ready = 1'b1; #1;
    check("pop1_req", 64'(bus.fetch_req), 64'(1));
    check("pop1_addr", 64'(bus.fetch_addr), 64'h004);
    tick(); bus.instr_ready = 1'b0; #1;
    check("pop1_head", 64'(bus.instr_pc), 64'h001);
    check("pop1_count", 64'(bus.count), 64'(3));
    check("pop1_no_req", 64'(bus.fetch_req), 64'(0));
    tick();
    check("refill_count", 64'(bus.count), 64'(4));

    // PC wrap
    bus.redirect = 1'b1; bus.redirect_pc = 11'h7FE; bus.instr_ready = 1'b1;
    #1;
    tick(); bus.redirect = 1'b0; #1;
    tick();
    tick();
    e_pc = 11'h7FE;
    for (int k = 0; k < 4; k++) begin
      check("wrap_valid", 64'(bus.instr_valid), 64'(1));
      check("wrap_pc", 64'(bus.instr_pc), 64'(e_pc));
      check("wrap_out", 64'(bus.instr_out), 64'hE000_0000 + 64'(e_pc));
      e_pc = e_pc + 11'h1;
      tick();
    end

    // Redirect while 0x023 returns
    bus.redirect = 1'b1; bus.redirect_pc = 11'h020;
    #1;
    tick(); bus.redirect = 1'b0; #1;
    tick();
    tick();
    check("s20_pc", 64'(bus.instr_pc), 64'h020);
    tick();
    check("s21_pc", 64'(bus.instr_pc), 64'h021);
    tick();
    check("s22_pc", 64'(bus.instr_pc), 64'h022);
    bus.redirect = 1'b1; bus.redirect_pc = 11'h100; #1;
    check("flush_req_low", 64'(bus.fetch_req), 64'(0));
    check("flush_pop_valid", 64'(bus.instr_valid), 64'(1));
    tick(); bus.redirect = 1'b0; #1;
    check("flush_count", 64'(bus.count), 64'(0));
    check("flush_valid", 64'(bus.instr_valid), 64'(0));
    check("flush_req", 64'(bus.fetch_req), 64'(1));
    check("flush_addr", 64'(bus.fetch_addr), 64'h100);
    tick();
    check("flush_t2_valid", 64'(bus.instr_valid), 64'(0));
    tick();
    check("flush_t3_valid", 64'(bus.instr_valid), 64'(1));
    check("flush_t3_pc", 64'(bus.instr_pc), 64'h100);
    check("flush_t3_out", 64'(bus.instr_out), 64'hE000_0100);

    // Halt for 5 cycles with consumer stalled
    bus.halt = 1'b1; bus.instr_ready = 1'b0; #1;
    check("halt_req", 64'(bus.fetch_req), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_req", 64'(bus.fetch_req), 64'(0));
    end
    check("halt_count", 64'(bus.count), 64'(2));
    check("halt_head", 64'(bus.instr_pc), 64'h100);
    tick(); bus.halt = 1'b0; bus.instr_ready = 1'b1; #1;
    check("resume_req", 64'(bus.fetch_req), 64'(1));
    check("resume_addr", 64'(bus.fetch_addr), 64'h102);
    e_pc = 11'h100;
    for (int k = 0; k < 4; k++) begin
      check("resume_pc", 64'(bus.instr_pc), 64'(e_pc));
      check("resume_valid", 64'(bus.instr_valid), 64'(1));
      e_pc = e_pc + 11'h1;
      tick();
    end

    // Asynchronous reset mid-fetch
    bus.redirect = 1'b1; bus.redirect_pc = 11'h040; bus.instr_ready = 1'b0;
    #1;
    tick(); bus.redirect = 1'b0; #1;
    for (int i = 0; i < 4; i++) tick();
    bus.instr_ready = 1'b1; #1;
    check("pre_rst_count", 64'(bus.count), 64'(3));
    check("pre_rst_req", 64'(bus.fetch_req), 64'(1));
    check("pre_rst_addr", 64'(bus.fetch_addr), 64'h044);
    rst_n = 1'b0; #1;
    check_zero("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_req", 64'(bus.fetch_req), 64'(0));
      check("post_rst_valid", 64'(bus.instr_valid), 64'(0));
      check("post_rst_count", 64'(bus.count), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
